alu_operand_stage: RTL and testbench

- Parametrised successor to the single-operand B-select mux. Selects and registers both ALU operands for the EX stage in one block.
- Operand A sources: rs1, PC, zero. Operand B sources: rs2, immediate. Both rs1 and rs2 are forwarded from the EX/MEM and MEM/WB stages.
- Sits between the ID/EX boundary and the ALU. Provides one-cycle registered operands with stall/flush control and a saturating forwarding-event counter for profiling.

---
 rtl/alu_operand_stage_if.sv | 44 ++++
 rtl/alu_operand_stage.sv | 106 ++++++++++
 tb/tb_alu_operand_stage.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/alu_operand_stage_if.sv
// Operand-stage bus: decoded-instruction inputs, forwarding sources and registered ALU operands.
// The master drives the instruction/forwarding side; the slave is the operand stage.
interface alu_operand_stage_if #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
);
  logic              in_valid;
  logic              stall;
  logic              flush;
  logic [REG_AW-1:0] rs1_addr;
  logic [REG_AW-1:0] rs2_addr;
  logic [XLEN-1:0]   rs1_data;
  logic [XLEN-1:0]   rs2_data;
  logic [XLEN-1:0]   pc_in;
  logic [XLEN-1:0]   imm_in;
  logic [1:0]        asel;
  logic              bsel;
  logic [REG_AW-1:0] mem_rd;
  logic [REG_AW-1:0] wb_rd;
  logic              mem_wen;
  logic              wb_wen;
  logic [XLEN-1:0]   mem_data;
  logic [XLEN-1:0]   wb_data;
  logic              out_valid;
  logic [XLEN-1:0]   alu_in1;
  logic [XLEN-1:0]   alu_in2;
  logic [XLEN-1:0]   store_data;
  logic [CNT_W-1:0]  fwd_count;

  modport master (
    output in_valid, stall, flush, rs1_addr, rs2_addr, rs1_data, rs2_data,
           pc_in, imm_in, asel, bsel, mem_rd, wb_rd, mem_wen, wb_wen,
           mem_data, wb_data,
    input  out_valid, alu_in1, alu_in2, store_data, fwd_count
  );

  modport slave (
    input  in_valid, stall, flush, rs1_addr, rs2_addr, rs1_data, rs2_data,
           pc_in, imm_in, asel, bsel, mem_rd, wb_rd, mem_wen, wb_wen,
           mem_data, wb_data,
    output out_valid, alu_in1, alu_in2, store_data, fwd_count
  );
endinterface

// File: rtl/alu_operand_stage.sv
// EX-stage operand select: forwards rs1/rs2 from MEM/WB, muxes A/B, registers them with
// stall/flush control, and keeps a saturating count of consumed forwards.
module alu_operand_stage #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
) (
  input logic               clk,
  input logic               rst,
  alu_operand_stage_if.slave bus
);

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] cnt,
                                               input logic [1:0]       inc);
    logic [CNT_W:0] sum;
    sum = {1'b0, cnt} + (CNT_W+1)'(inc);
    if (sum[CNT_W]) return '1;
    return sum[CNT_W-1:0];
  endfunction

  logic             rs1_mem_hit, rs1_wb_hit, rs2_mem_hit, rs2_wb_hit;
  logic             rs1_hit, rs2_hit;
  logic [XLEN-1:0]  fwd_rs1, fwd_rs2;
  logic [XLEN-1:0]  op_a, op_b;
  logic [1:0]       fwd_inc;

  logic             out_valid_q, out_valid_d;
  logic [XLEN-1:0]  alu_in1_q, alu_in1_d;
  logic [XLEN-1:0]  alu_in2_q, alu_in2_d;
  logic [XLEN-1:0]  store_data_q, store_data_d;
  logic [CNT_W-1:0] fwd_count_q, fwd_count_d;

  // Forward resolution: MEM beats WB, x0 always reads the register file.
  always_comb begin
    rs1_mem_hit = bus.mem_wen && (bus.mem_rd == bus.rs1_addr) && (bus.rs1_addr != '0);
    rs1_wb_hit  = bus.wb_wen  && (bus.wb_rd  == bus.rs1_addr) && (bus.rs1_addr != '0);
    rs2_mem_hit = bus.mem_wen && (bus.mem_rd == bus.rs2_addr) && (bus.rs2_addr != '0);
    rs2_wb_hit  = bus.wb_wen  && (bus.wb_rd  == bus.rs2_addr) && (bus.rs2_addr != '0);
    rs1_hit     = rs1_mem_hit || rs1_wb_hit;
    rs2_hit     = rs2_mem_hit || rs2_wb_hit;
    fwd_rs1     = rs1_mem_hit ? bus.mem_data : (rs1_wb_hit ? bus.wb_data : bus.rs1_data);
    fwd_rs2     = rs2_mem_hit ? bus.mem_data : (rs2_wb_hit ? bus.wb_data : bus.rs2_data);
  end

  always_comb begin
    case (bus.asel)
      2'd0:    op_a = fwd_rs1;
      2'd1:    op_a = bus.pc_in;
      default: op_a = '0;
    endcase
    op_b = bus.bsel ? bus.imm_in : fwd_rs2;
    // A forwarded rs2 is always consumed, by the ALU or by the store path.
    fwd_inc = {1'b0, rs1_hit && (bus.asel == 2'd0)} + {1'b0, rs2_hit};
  end

  always_comb begin
    out_valid_d  = out_valid_q;
    alu_in1_d    = alu_in1_q;
    alu_in2_d    = alu_in2_q;
    store_data_d = store_data_q;
    fwd_count_d  = fwd_count_q;
    if (bus.flush) begin
      out_valid_d  = 1'b0;
      alu_in1_d    = '0;
      alu_in2_d    = '0;
      store_data_d = '0;
    end else if (!bus.stall) begin
      if (bus.in_valid) begin
        out_valid_d  = 1'b1;
        alu_in1_d    = op_a;
        alu_in2_d    = op_b;
        store_data_d = fwd_rs2;
        fwd_count_d  = sat_add(fwd_count_q, fwd_inc);
      end else begin
        out_valid_d  = 1'b0;
        alu_in1_d    = '0;
        alu_in2_d    = '0;
        store_data_d = '0;
      end
    end
  end

  // Stage boundary: registered operands to the ALU.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q  <= 1'b0;
      alu_in1_q    <= '0;
      alu_in2_q    <= '0;
      store_data_q <= '0;
      fwd_count_q  <= '0;
    end else begin
      out_valid_q  <= out_valid_d;
      alu_in1_q    <= alu_in1_d;
      alu_in2_q    <= alu_in2_d;
      store_data_q <= store_data_d;
      fwd_count_q  <= fwd_count_d;
    end
  end

  assign bus.out_valid  = out_valid_q;
  assign bus.alu_in1    = alu_in1_q;
  assign bus.alu_in2    = alu_in2_q;
  assign bus.store_data = store_data_q;
  assign bus.fwd_count  = fwd_count_q;

endmodule

// File: tb/tb_alu_operand_stage.sv
// Directed bench for alu_operand_stage: two instances (16-bit and 2-bit counters) share stimulus;
// expected outputs per cycle are queued by the stimulus and checked by an independent monitor.
module tb_alu_operand_stage;

  logic        clk;
  logic        rst;
  logic        in_valid, stall, flush, bsel, mem_wen, wb_wen;
  logic [4:0]  rs1_addr, rs2_addr, mem_rd, wb_rd;
  logic [31:0] rs1_data, rs2_data, pc_in, imm_in, mem_data, wb_data;
  logic [1:0]  asel;

  alu_operand_stage_if #(.XLEN(32), .REG_AW(5), .CNT_W(16)) if16 ();
  alu_operand_stage_if #(.XLEN(32), .REG_AW(5), .CNT_W(2))  if2 ();

  assign if16.in_valid = in_valid;  assign if2.in_valid = in_valid;
  assign if16.stall    = stall;     assign if2.stall    = stall;
  assign if16.flush    = flush;     assign if2.flush    = flush;
  assign if16.rs1_addr = rs1_addr;  assign if2.rs1_addr = rs1_addr;
  assign if16.rs2_addr = rs2_addr;  assign if2.rs2_addr = rs2_addr;
  assign if16.rs1_data = rs1_data;  assign if2.rs1_data = rs1_data;
  assign if16.rs2_data = rs2_data;  assign if2.rs2_data = rs2_data;
  assign if16.pc_in    = pc_in;     assign if2.pc_in    = pc_in;
  assign if16.imm_in   = imm_in;    assign if2.imm_in   = imm_in;
  assign if16.asel     = asel;      assign if2.asel     = asel;
  assign if16.bsel     = bsel;      assign if2.bsel     = bsel;
  assign if16.mem_rd   = mem_rd;    assign if2.mem_rd   = mem_rd;
  assign if16.wb_rd    = wb_rd;     assign if2.wb_rd    = wb_rd;
  assign if16.mem_wen  = mem_wen;   assign if2.mem_wen  = mem_wen;
  assign if16.wb_wen   = wb_wen;    assign if2.wb_wen   = wb_wen;
  assign if16.mem_data = mem_data;  assign if2.mem_data = mem_data;
  assign if16.wb_data  = wb_data;   assign if2.wb_data  = wb_data;

  alu_operand_stage #(.XLEN(32), .REG_AW(5), .CNT_W(16)) dut16 (.clk(clk), .rst(rst), .bus(if16));
  alu_operand_stage #(.XLEN(32), .REG_AW(5), .CNT_W(2))  dut2  (.clk(clk), .rst(rst), .bus(if2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        v;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] st;
    logic [15:0] c16;
    logic [1:0]  c2;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc_idx  = 0;
  bit   done     = 1'b0;

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL c%0d %s: got %h, want %h", idx, name, act, req);
    end
  endtask

  // Monitor: one expectation per clock edge, compared just after the edge.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("out_valid",     cyc_idx, 32'(if16.out_valid), 32'(e.v));
      chk("alu_in1",       cyc_idx, if16.alu_in1,        e.a);
      chk("alu_in2",       cyc_idx, if16.alu_in2,        e.b);
      chk("store_data",    cyc_idx, if16.store_data,     e.st);
      chk("fwd_count16",   cyc_idx, 32'(if16.fwd_count), 32'(e.c16));
      chk("out_valid_w2",  cyc_idx, 32'(if2.out_valid),  32'(e.v));
      chk("alu_in1_w2",    cyc_idx, if2.alu_in1,         e.a);
      chk("store_data_w2", cyc_idx, if2.store_data,      e.st);
      chk("fwd_count2",    cyc_idx, 32'(if2.fwd_count),  32'(e.c2));
      cyc_idx++;
    end else if (!done && (if16.out_valid === 1'b1 || if2.out_valid === 1'b1)) begin
      chk("unexpected_valid", cyc_idx, 32'(if16.out_valid), 32'd0);
    end
  end

  task automatic clr();
    in_valid = 0; stall = 0; flush = 0; bsel = 0; mem_wen = 0; wb_wen = 0;
    rs1_addr = 0; rs2_addr = 0; mem_rd = 0; wb_rd = 0; asel = 0;
    rs1_data = 0; rs2_data = 0; pc_in = 0; imm_in = 0; mem_data = 0; wb_data = 0;
  endtask

  task automatic step(input logic v, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] st, input logic [15:0] c16, input logic [1:0] c2);
    exp_t e;
    e = '{v: v, a: a, b: b, st: st, c16: c16, c2: c2};
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  initial begin
    clr(); rst = 1;
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    rst = 0;
    step(0, 0, 0, 0, 0, 0);

    // No hazard
    clr(); in_valid = 1; rs1_addr = 1; rs2_addr = 2; rs1_data = 32'h11; rs2_data = 32'h22;
    step(1, 32'h11, 32'h22, 32'h22, 0, 0);

    // MEM beats WB on rs1
    clr(); in_valid = 1; rs1_addr = 5; rs1_data = 32'h55; rs2_addr = 6; rs2_data = 32'h66;
    mem_rd = 5; wb_rd = 5; mem_wen = 1; wb_wen = 1; mem_data = 32'hAAAA; wb_data = 32'hBBBB;
    step(1, 32'hAAAA, 32'h66, 32'h66, 1, 1);
    rs1_addr = 0; mem_rd = 0; wb_rd = 0;
    step(1, 32'h55, 32'h66, 32'h66, 1, 1);

    // PC as A: rs1 forward present but not consumed
    rs1_addr = 5; mem_rd = 5; asel = 1; pc_in = 32'h1000;
    step(1, 32'h1000, 32'h66, 32'h66, 1, 1);
    asel = 3; rs1_data = 32'h77;
    step(1, 32'h0, 32'h66, 32'h66, 1, 1);

    // Immediate B, rs2 forwarded from WB to the store path
    clr(); in_valid = 1; rs1_addr = 1; rs1_data = 32'h11; bsel = 1; imm_in = 32'hFFFF_FFF0;
    rs2_addr = 3; rs2_data = 32'h33; wb_rd = 3; wb_wen = 1; wb_data = 32'h1234;
    step(1, 32'h11, 32'hFFFF_FFF0, 32'h1234, 2, 2);

    // Load then stall with changing inputs
    clr(); in_valid = 1; rs1_addr = 7; rs1_data = 32'h70; rs2_addr = 8; rs2_data = 32'h80;
    step(1, 32'h70, 32'h80, 32'h80, 2, 2);
    stall = 1; mem_rd = 7; mem_wen = 1; mem_data = 32'hDEAD; rs2_data = 32'hBEEF;
    step(1, 32'h70, 32'h80, 32'h80, 2, 2);
    rs1_data = 32'h1; asel = 1; pc_in = 32'h2000;
    step(1, 32'h70, 32'h80, 32'h80, 2, 2);
    in_valid = 0;
    step(1, 32'h70, 32'h80, 32'h80, 2, 2);
    in_valid = 1; flush = 1;
    step(0, 0, 0, 0, 2, 2);

    // Valid then bubble
    clr(); in_valid = 1; rs1_addr = 9; rs1_data = 32'h90; rs2_addr = 10; rs2_data = 32'hA0;
    step(1, 32'h90, 32'hA0, 32'hA0, 2, 2);
    in_valid = 0;
    step(0, 0, 0, 0, 2, 2);

    // Double forward then reset mid-operation
    clr(); in_valid = 1; rs1_addr = 4; rs2_addr = 4; rs1_data = 32'h1; rs2_data = 32'h2;
    mem_rd = 4; mem_wen = 1; mem_data = 32'h4444;
    step(1, 32'h4444, 32'h4444, 32'h4444, 4, 3);
    rst = 1; flush = 1;
    step(0, 0, 0, 0, 0, 0);
    rst = 0; flush = 0;

    // Saturation on the 2-bit counter
    clr(); in_valid = 1; rs1_addr = 9; rs2_addr = 9; rs1_data = 32'h5; rs2_data = 32'h6;
    mem_rd = 9; mem_wen = 1; mem_data = 32'h98; wb_rd = 9; wb_wen = 1; wb_data = 32'h99;
    step(1, 32'h98, 32'h98, 32'h98, 2, 2);
    step(1, 32'h98, 32'h98, 32'h98, 4, 3);
    step(1, 32'h98, 32'h98, 32'h98, 6, 3);
    clr();
    step(0, 0, 0, 0, 6, 3);

    for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge clk);
    done = 1'b1;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
